// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns fetch PC, single-outstanding imem
// handshake, small instruction FIFO toward decode, redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;

  logic [31:0]   fpc_q  [DEPTH];
  logic [31:0]   fins_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d, cnt_pop;
  logic          push, pop;
  logic [31:0]   target;

  assign target  = pc_next & 32'hFFFF_FFFC;
  assign pop     = (cnt_q != '0) && id_ready && !pc_write;
  assign cnt_pop = cnt_q - {{AW{1'b0}}, pop};
  assign cnt_d   = cnt_pop + {{AW{1'b0}}, push};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pc_write) begin
          pc_d = target;
        end else if (cnt_pop < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (pc_write) begin
          pc_d    = target;
          state_d = imem_ack ? IDLE : DROP;
          req_d   = !imem_ack;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (pc_write) pc_d = target;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      if (pc_write) begin
        cnt_q <= '0;
        rd_q  <= '0;
        wr_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[wr_q]  <= pc_q;
      fins_q[wr_q] <= imem_rdata;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = (cnt_q != '0);
  assign if_pc     = fpc_q[rd_q];
  assign if_instr  = fins_q[rd_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder, decode monitor,
// hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  fetch_unit #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_write  (pc_write),
    .pc_next   (pc_next),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .id_ready  (id_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] iaddr[$];
  logic [31:0] dpc[$];
  logic [31:0] dins[$];
  int   lat  = 1;
  int   wcnt = 0;
  logic hold = 1'b0;
  logic bad  = 1'b0;
  logic prev_req = 1'b0;
  logic saw_dead = 1'b0;

  // Memory responder and decode monitor, mid-cycle.
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else begin
      if (!prev_req) iaddr.push_back(imem_addr);
      if (!hold && wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = bad ? 32'hDEAD_BEEF : dat(imem_addr);
        bad        = 1'b0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end
    prev_req = imem_req;
    if (!rst && if_valid && if_instr == 32'hDEAD_BEEF) saw_dead = 1'b1;
    if (!rst && if_valid && id_ready && !pc_write) begin
      dpc.push_back(if_pc);
      dins.push_back(if_instr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iaddr.delete();
    dpc.delete();
    dins.delete();
  endtask

  initial begin
    rst        = 1'b1;
    pc_write   = 1'b0;
    pc_next    = '0;
    id_ready   = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_val", {31'd0, if_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);

    // steady fetch
    for (int i = 0; i < 200 && dpc.size() < 3; i++) tick(1);
    chk("t1_n", {31'd0, dpc.size() >= 3}, 32'd1);
    if (dpc.size() >= 3 && iaddr.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t1_addr%0d", k), iaddr[k], 32'h100 + 32'(4*k));
        chk($sformatf("t1_pc%0d", k), dpc[k], 32'h100 + 32'(4*k));
        chk($sformatf("t1_ins%0d", k), dins[k], dat(32'h100 + 32'(4*k)));
      end
    end

    // backpressure
    rst      = 1'b1;
    id_ready = 1'b0;
    tick(2);
    clr();
    rst = 1'b0;
    tick(20);
    chk("t2_nreq", iaddr.size(), 32'd2);
    if (iaddr.size() >= 2) begin
      chk("t2_a0", iaddr[0], 32'h100);
      chk("t2_a1", iaddr[1], 32'h104);
    end
    chk("t2_idle", {31'd0, imem_req}, 32'd0);
    chk("t2_val", {31'd0, if_valid}, 32'd1);
    chk("t2_pc", if_pc, 32'h100);
    chk("t2_ins", if_instr, dat(32'h100));
    id_ready = 1'b1;
    tick(1);
    chk("t2_req", {31'd0, imem_req}, 32'd1);
    chk("t2_addr", imem_addr, 32'h108);
    chk("t2_head", if_pc, 32'h104);

    // redirect with request outstanding
    hold = 1'b1;
    tick(1);
    clr();
    pc_write = 1'b1;
    pc_next  = 32'h2002;
    tick(1);
    pc_write = 1'b0;
    chk("t3_val", {31'd0, if_valid}, 32'd0);
    chk("t3_hreq", {31'd0, imem_req}, 32'd1);
    chk("t3_haddr", imem_addr, 32'h108);
    tick(2);
    bad  = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 200 && dpc.size() < 1; i++) tick(1);
    chk("t3_n", {31'd0, dpc.size() >= 1}, 32'd1);
    if (dpc.size() >= 1 && iaddr.size() >= 1) begin
      chk("t3_a0", iaddr[0], 32'h2000);
      chk("t3_pc", dpc[0], 32'h2000);
      chk("t3_ins", dins[0], dat(32'h2000));
    end

    // redirect coincident with ack and pop, one entry buffered
    rst      = 1'b1;
    id_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 100 && !if_valid; i++) tick(1);
    hold = 1'b1;
    tick(3);
    chk("t4_pre", {30'd0, imem_req, if_valid}, 32'd3);
    clr();
    hold     = 1'b0;
    pc_write = 1'b1;
    pc_next  = 32'h3000;
    id_ready = 1'b1;
    tick(1);
    pc_write = 1'b0;
    chk("t4_val", {31'd0, if_valid}, 32'd0);
    chk("t4_idle", {31'd0, imem_req}, 32'd0);
    tick(1);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h3000);
    for (int i = 0; i < 200 && dpc.size() < 1; i++) tick(1);
    chk("t4_n", {31'd0, dpc.size() >= 1}, 32'd1);
    if (dpc.size() >= 1) chk("t4_pc", dpc[0], 32'h3000);

    // back-to-back redirects while dropping
    hold = 1'b1;
    for (int i = 0; i < 100 && !imem_req; i++) tick(1);
    tick(1);
    clr();
    pc_write = 1'b1;
    pc_next  = 32'h400;
    tick(1);
    pc_next = 32'h800;
    tick(1);
    pc_write = 1'b0;
    chk("t5_hold", {31'd0, imem_req}, 32'd1);
    tick(2);
    hold = 1'b0;
    for (int i = 0; i < 200 && dpc.size() < 2; i++) tick(1);
    chk("t5_n", {31'd0, dpc.size() >= 2}, 32'd1);
    if (dpc.size() >= 2 && iaddr.size() >= 2) begin
      chk("t5_a0", iaddr[0], 32'h800);
      chk("t5_a1", iaddr[1], 32'h804);
      chk("t5_pc0", dpc[0], 32'h800);
      chk("t5_pc1", dpc[1], 32'h804);
    end

    // reset mid-operation
    rst      = 1'b1;
    id_ready = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 100 && !if_valid; i++) tick(1);
    hold = 1'b1;
    tick(2);
    chk("t6_pre", {30'd0, imem_req, if_valid}, 32'd3);
    rst = 1'b1;
    tick(1);
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_val", {31'd0, if_valid}, 32'd0);
    chk("t6_addr", imem_addr, 32'h100);
    clr();
    hold = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 100 && iaddr.size() < 1; i++) tick(1);
    chk("t6_n", iaddr.size(), 32'd1);
    if (iaddr.size() >= 1) chk("t6_a0", iaddr[0], 32'h100);

    chk("no_dead", {31'd0, saw_dead}, 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
